// File: rtl/alu_mux_arbiter.sv
// -----------------------------------------------------------------------------
// alu_mux_arbiter
//
// Round-robin arbiter and sequencer for the shared 8:1 result multiplexer in
// the ALU datapath. Each transfer grants one of eight requesters and drives
// the mux select lines. The mux output is captured into a result register and
// handed downstream over a VALID/READY handshake. Throughput is one word per
// cycle.
//
// Optional feature macro: ALU_ARB_LOCK_EN
//   When defined, the LOCK input exists. A grant made with LOCK=1 leaves the
//   winner at top priority for the next arbitration.
//
// Ports:
//   CLK    in  1   sole clock, rising edge
//   RST    in  1   synchronous active-high reset
//   REQ    in  8   per-requester request; bit i means Di on the mux is valid
//   LOCK   in  1   (ALU_ARB_LOCK_EN only) keep priority with the winner
//   MUX_Y  in  W   output of the external 8:1 mux
//   READY  in  1   downstream accepts DOUT this cycle
//   SEL    out 3   mux select
//   ACK    out 8   one-hot, combinational: Di is sampled at this edge
//   DOUT   out W   registered captured data
//   VALID  out 1   DOUT holds an unconsumed word
// -----------------------------------------------------------------------------
module alu_mux_arbiter #(
    parameter int W = 6
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [7:0]   REQ,
`ifdef ALU_ARB_LOCK_EN
    input  logic         LOCK,
`endif
    input  logic [W-1:0] MUX_Y,
    input  logic         READY,
    output logic [2:0]   SEL,
    output logic [7:0]   ACK,
    output logic [W-1:0] DOUT,
    output logic         VALID
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]   state_reg;
    logic [2:0]   ptr_reg;
    logic [2:0]   gidx_reg;
    logic [W-1:0] dout_reg;

    logic [7:0]   rot_req;
    logic [2:0]   win_offset;
    logic [2:0]   win_idx;
    logic         can_arb;
    logic         grant;
    logic [2:0]   ptr_next;

    // A new word may be taken when the result register is empty, or when the
    // word it holds is being consumed at this same edge.
    assign can_arb = (state_reg == ST_EMPTY) || READY;
    assign grant   = can_arb && (REQ != 8'd0) && !RST;

    // Rotate the request vector so that position 0 is the requester at PTR.
    // The first set bit of the rotated vector is then the winner's distance
    // from PTR; the 3-bit sum wraps modulo 8 on its own.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_req[gi] = REQ[ptr_reg + 3'(gi)];
        end
    endgenerate

    always_comb begin
        win_offset = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (rot_req[k]) begin
                win_offset = 3'(k);
            end
        end
    end

    assign win_idx = ptr_reg + win_offset;

`ifdef ALU_ARB_LOCK_EN
    assign ptr_next = LOCK ? win_idx : win_idx + 3'd1;
`else
    assign ptr_next = win_idx + 3'd1;
`endif

    // SEL shows the live winner during a grant. Otherwise it parks on the last
    // granted index, so the mux input does not move under a held word. During
    // reset SEL is forced to 0 because GIDX may not have been cleared yet.
    always_comb begin
        SEL = gidx_reg;
        ACK = 8'd0;
        if (RST) begin
            SEL = 3'd0;
        end else if (grant) begin
            SEL = win_idx;
            ACK = 8'd1 << win_idx;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_EMPTY;
            ptr_reg   <= 3'd0;
            gidx_reg  <= 3'd0;
            dout_reg  <= '0;
        end else if (grant) begin
            // Any old word is consumed at this edge (READY=1 or EMPTY).
            state_reg <= ST_FULL;
            dout_reg  <= MUX_Y;
            gidx_reg  <= win_idx;
            ptr_reg   <= ptr_next;
        end else if (can_arb) begin
            // No request: a FULL word, if any, drains and the register empties.
            state_reg <= ST_EMPTY;
        end
    end

    assign DOUT  = dout_reg;
    assign VALID = (state_reg == ST_FULL);

endmodule

// File: tb/tb_alu_mux_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for alu_mux_arbiter: directed vectors with literal expectations,
// plus a transaction-level reference model checked against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_alu_mux_arbiter;

    localparam int W = 6;

    logic         CLK;
    logic         RST;
    logic [7:0]   REQ;
    logic         LOCK;
    logic [W-1:0] MUX_Y;
    logic         READY;
    logic [2:0]   SEL;
    logic [7:0]   ACK;
    logic [W-1:0] DOUT;
    logic         VALID;

    int checks   = 0;
    int failures = 0;

    alu_mux_arbiter #(.W(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
`ifdef ALU_ARB_LOCK_EN
        .LOCK  (LOCK),
`endif
        .MUX_Y (MUX_Y),
        .READY (READY),
        .SEL   (SEL),
        .ACK   (ACK),
        .DOUT  (DOUT),
        .VALID (VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Holds the queue of one pending word plus the round-robin start index.
    bit           m_known = 0;
    bit           m_valid;
    int           m_ptr;
    int           m_gidx;
    int           m_dout;

    function automatic int find_winner(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    function automatic bit lock_now();
`ifdef ALU_ARB_LOCK_EN
        return LOCK;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge CLK) begin
        int w;
        if (RST) begin
            m_known = 1;
            m_valid = 0;
            m_ptr   = 0;
            m_gidx  = 0;
            m_dout  = 0;
        end else if (m_known) begin
            if (!m_valid || READY) begin
                w = find_winner(REQ, m_ptr);
                if (w >= 0) begin
                    m_dout  = int'(MUX_Y);
                    m_gidx  = w;
                    m_ptr   = lock_now() ? w : (w + 1) % 8;
                    m_valid = 1;
                end else begin
                    m_valid = 0;
                end
            end
        end
    end

    // Compare process: away from the active edge, with inputs settled.
    always @(negedge CLK) begin
        int w;
        int e_sel;
        int e_ack;
        if (RST) begin
            check("cyc_ack_in_reset", 32'(ACK), 32'd0);
            check("cyc_sel_in_reset", 32'(SEL), 32'd0);
        end else if (m_known) begin
            w = ((!m_valid || READY) && REQ != 8'd0) ? find_winner(REQ, m_ptr) : -1;
            e_sel = (w >= 0) ? w : m_gidx;
            e_ack = (w >= 0) ? (1 << w) : 0;
            check("cyc_sel", 32'(SEL), 32'(e_sel));
            check("cyc_ack", 32'(ACK), 32'(e_ack));
        end
        if (m_known) begin
            check("cyc_valid", 32'(VALID), 32'(m_valid));
            check("cyc_dout", 32'(DOUT), 32'(m_dout));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [W-1:0] held;

    initial begin
        RST = 1'b1; REQ = 8'hFF; READY = 1'b1; MUX_Y = '0; LOCK = 1'b0;

        // Reset with every requester asking.
        for (int i = 0; i < 3; i++) begin
            settle();
            check("rst_ack", 32'(ACK), 32'd0);
            check("rst_sel", 32'(SEL), 32'd0);
            step();
            check("rst_valid", 32'(VALID), 32'd0);
            check("rst_dout", 32'(DOUT), 32'd0);
            $display("reset cycle %0d ACK=%h SEL=%0d VALID=%0d DOUT=%h", i, ACK, SEL, VALID, DOUT);
        end
        RST = 1'b0; REQ = 8'h00;
        step();
        check("post_rst_valid", 32'(VALID), 32'd0);
        check("post_rst_dout", 32'(DOUT), 32'd0);

        // Single grant to index 2.
        REQ = 8'h04; MUX_Y = 6'h2A;
        settle();
        check("single_ack", 32'(ACK), 32'h04);
        check("single_sel", 32'(SEL), 32'd2);
        step();
        REQ = 8'h00;
        check("single_valid", 32'(VALID), 32'd1);
        check("single_dout", 32'(DOUT), 32'h2A);
        $display("single grant SEL=2 DOUT=%h VALID=%0d", DOUT, VALID);
        // PTR must now be 3: all requesting picks index 3.
        REQ = 8'hFF;
        settle();
        check("single_ptr3_sel", 32'(SEL), 32'd3);
        check("single_ptr3_ack", 32'(ACK), 32'h08);

        // Full rotation from PTR=0.
        RST = 1'b1;
        step();
        RST = 1'b0; REQ = 8'hFF; READY = 1'b1;
        for (int i = 0; i < 9; i++) begin
            MUX_Y = 6'(i * 7 + 1);
            settle();
            check("rot_sel", 32'(SEL), 32'(i % 8));
            step();
            check("rot_valid", 32'(VALID), 32'd1);
            check("rot_dout", 32'(DOUT), 32'(i * 7 + 1));
            $display("rotation grant %0d DOUT=%h", i % 8, DOUT);
        end

        // Backpressure after a grant to index 5 (PTR is 1 here).
        REQ = 8'h20; MUX_Y = 6'h15;
        step();
        REQ = 8'hFF; READY = 1'b0; MUX_Y = 6'h3F;
        held = DOUT;
        check("bp_dout_captured", 32'(held), 32'h15);
        for (int i = 0; i < 4; i++) begin
            settle();
            check("bp_ack", 32'(ACK), 32'd0);
            check("bp_sel", 32'(SEL), 32'd5);
            step();
            check("bp_valid", 32'(VALID), 32'd1);
            check("bp_dout", 32'(DOUT), 32'(held));
            $display("backpressure cycle %0d SEL=%0d DOUT=%h", i, SEL, DOUT);
        end
        READY = 1'b1; MUX_Y = 6'h06;
        settle();
        check("bp_release_ack", 32'(ACK), 32'h40);
        step();
        check("bp_release_dout", 32'(DOUT), 32'h06);

        // Wrap and skip: PTR=7, only requesters 0 and 1.
        REQ = 8'h03; MUX_Y = 6'h10;
        settle();
        check("wrap_sel0", 32'(SEL), 32'd0);
        step();
        MUX_Y = 6'h11;
        settle();
        check("wrap_sel1", 32'(SEL), 32'd1);
        step();
        check("wrap_dout", 32'(DOUT), 32'h11);
        REQ = 8'hFF;
        settle();
        check("wrap_ptr2_sel", 32'(SEL), 32'd2);
        $display("wrap and skip grants 0,1 then SEL=%0d", SEL);

        // Drain: no request with READY empties the register; DOUT holds.
        REQ = 8'h00;
        step();
        check("drain_valid", 32'(VALID), 32'd0);
        check("drain_dout", 32'(DOUT), 32'h11);
        step();
        check("idle_sel", 32'(SEL), 32'd1);

        // Reset while FULL discards the word.
        REQ = 8'h80; MUX_Y = 6'h22;
        step();
        check("full_before_rst", 32'(VALID), 32'd1);
        RST = 1'b1; REQ = 8'hFF; READY = 1'b0;
        settle();
        check("rst_full_ack", 32'(ACK), 32'd0);
        step();
        check("rst_full_valid", 32'(VALID), 32'd0);
        check("rst_full_dout", 32'(DOUT), 32'd0);
        RST = 1'b0; READY = 1'b1; REQ = 8'h00;
        step();
        $display("reset during FULL VALID=%0d DOUT=%h", VALID, DOUT);

`ifdef ALU_ARB_LOCK_EN
        // Bring PTR to 5 with an unlocked grant to index 4.
        REQ = 8'h10; LOCK = 1'b0;
        step();
        REQ = 8'h21; LOCK = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) LOCK = 1'b0;
            settle();
            check("lock_sel5", 32'(SEL), 32'd5);
            step();
            $display("lock grant %0d SEL=5", i);
        end
        settle();
        check("unlock_sel0", 32'(SEL), 32'd0);
        step();
        REQ = 8'h00;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
